// File: rtl/qspi_bus_arbiter_pkg.sv
// Shared definitions for the QSPI bus arbiter.
//   - Target select encodings (address bits [24:23]).
//   - Access size encodings (shared by d_size and eng_size).
//   - Arbiter FSM state enum.
//   - is_illegal(): classifies an access that must be rejected without
//     touching the engine.
package qspi_bus_arbiter_pkg;

  localparam logic [1:0] SEL_FLASH = 2'b00;
  localparam logic [1:0] SEL_RAMA  = 2'b10;
  localparam logic [1:0] SEL_RAMB  = 2'b11;
  localparam logic [1:0] SEL_BAD   = 2'b01;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_BAD  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BUSY,
    ST_ACK,
    ST_ERR,
    ST_GAP
  } state_t;

  // Unmapped window, any size code 3, or a write to read-only flash.
  function automatic logic is_illegal(input logic [1:0] sel,
                                      input logic       write,
                                      input logic [1:0] size);
    return !(sel inside {SEL_FLASH, SEL_RAMA, SEL_RAMB}) ||
           !(size inside {SIZE_BYTE, SIZE_HALF, SIZE_WORD}) ||
           (write && (sel == SEL_FLASH));
  endfunction

endpackage

// File: rtl/qspi_arb_pick.sv
// Winner selection between the fetch and data ports, plus the fetch
// streak counter that bounds how long a pending data request can starve.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   i_f_req       fetch request pending
//   i_d_req       data request pending
//   i_grant       a grant is being made this cycle (arbiter in IDLE)
//   o_pick_data   1 = data port wins, 0 = fetch port wins
module qspi_arb_pick
  import qspi_bus_arbiter_pkg::*;
#(
  parameter int FETCH_STREAK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_f_req,
  input  logic i_d_req,
  input  logic i_grant,
  output logic o_pick_data
);

  logic [2:0] r_streak;

  // Fetch has priority until it has won FETCH_STREAK times in a row
  // against a waiting data request.
  assign o_pick_data = i_d_req && (!i_f_req || (r_streak == 3'(FETCH_STREAK)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge value of every other flop.
      r_streak <= '0;
    end else if (i_grant) begin
      if (o_pick_data || !i_d_req) begin
        r_streak <= '0;
      end else if (r_streak != 3'd7) begin
        r_streak <= r_streak + 3'd1;
      end
    end
  end

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Arbitrates the shared QSPI engine between the CPU fetch and data ports.
// One transaction at a time; enforces a CS idle gap, bounded fetch streak,
// rejection of illegal accesses and recovery from a hung engine.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   f_req/f_addr                  fetch request (always a 4-byte read)
//   f_ack/f_err/f_rdata           fetch completion
//   d_req/d_addr/d_write/d_size/d_wdata   data request
//   d_ack/d_err/d_rdata           data completion
//   eng_start/sel/addr/write/size/wdata   transaction to the engine
//   eng_abort                     timeout abort to the engine
//   eng_done/eng_rdata            engine completion
//   busy                          arbiter not in IDLE
module qspi_bus_arbiter
  import qspi_bus_arbiter_pkg::*;
#(
  parameter int FETCH_STREAK = 4,
  parameter int CS_GAP       = 2,
  parameter int TIMEOUT      = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [24:0] f_addr,
  output logic        f_ack,
  output logic        f_err,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic [24:0] d_addr,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        eng_start,
  output logic [1:0]  eng_sel,
  output logic [22:0] eng_addr,
  output logic        eng_write,
  output logic [1:0]  eng_size,
  output logic [31:0] eng_wdata,
  output logic        eng_abort,
  input  logic        eng_done,
  input  logic [31:0] eng_rdata,
  output logic        busy
);

  localparam int GW = (CS_GAP > 2) ? $clog2(CS_GAP) : 1;

  state_t      r_state, w_state_nxt;
  logic        w_grant, w_pick_data;
  logic [24:0] w_win_addr;
  logic        w_win_write, w_win_bad;
  logic [1:0]  w_win_size;
  logic [31:0] w_win_wdata;
  logic [9:0]  w_tmo_inc;
  logic        w_tmo_hit, w_gap_last;

  logic [1:0]  r_sel;
  logic [22:0] r_addr;
  logic        r_write;
  logic [1:0]  r_size;
  logic [31:0] r_wdata;
  logic        r_win_data;
  logic        r_illegal;
  logic [31:0] r_f_rdata, r_d_rdata;
  logic [9:0]  r_tmo;
  logic [GW-1:0] r_gap;

  assign w_grant = (r_state == ST_IDLE) && (f_req || d_req);

  qspi_arb_pick #(.FETCH_STREAK(FETCH_STREAK)) u_pick (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_f_req    (f_req),
    .i_d_req    (d_req),
    .i_grant    (w_grant),
    .o_pick_data(w_pick_data)
  );

  assign w_win_addr  = w_pick_data ? d_addr : f_addr;
  assign w_win_write = w_pick_data && d_write;
  assign w_win_size  = w_pick_data ? d_size : SIZE_WORD;
  assign w_win_wdata = w_pick_data ? d_wdata : '0;
  assign w_win_bad   = is_illegal(w_win_addr[24:23], w_win_write, w_win_size);

  // r_tmo counts completed BUSY cycles, so the current BUSY cycle number is
  // r_tmo + 1; the abort fires in BUSY cycle TIMEOUT.
  assign w_tmo_inc  = r_tmo + 10'd1;
  assign w_tmo_hit  = (w_tmo_inc == 10'(TIMEOUT));
  assign w_gap_last = (r_gap == GW'(CS_GAP - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    w_state_nxt = r_state;
    eng_start   = 1'b0;
    eng_abort   = 1'b0;
    f_ack       = 1'b0;
    f_err       = 1'b0;
    d_ack       = 1'b0;
    d_err       = 1'b0;
    busy        = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: if (w_grant) w_state_nxt = w_win_bad ? ST_ERR : ST_ISSUE;
      ST_ISSUE: begin
        eng_start   = 1'b1;
        w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (eng_done) begin
          w_state_nxt = ST_ACK;
        end else if (w_tmo_hit) begin
          eng_abort   = 1'b1;
          w_state_nxt = ST_ERR;
        end
      end
      ST_ACK: begin
        f_ack       = !r_win_data;
        d_ack       = r_win_data;
        w_state_nxt = (CS_GAP == 0) ? ST_IDLE : ST_GAP;
      end
      ST_ERR: begin
        f_ack       = !r_win_data;
        f_err       = !r_win_data;
        d_ack       = r_win_data;
        d_err       = r_win_data;
        // Rejected accesses never drove CS, so no gap is owed.
        w_state_nxt = (r_illegal || CS_GAP == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: if (w_gap_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, because all outputs,
      // including rdata and the eng_* buses, must read 0 out of reset.
      r_sel      <= '0;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_size     <= '0;
      r_wdata    <= '0;
      r_win_data <= 1'b0;
      r_illegal  <= 1'b0;
      r_f_rdata  <= '0;
      r_d_rdata  <= '0;
      r_tmo      <= '0;
      r_gap      <= '0;
    end else begin
      if (w_grant) begin
        r_sel      <= w_win_addr[24:23];
        r_addr     <= w_win_addr[22:0];
        r_write    <= w_win_write;
        r_size     <= w_win_size;
        r_wdata    <= w_win_wdata;
        r_win_data <= w_pick_data;
        r_illegal  <= w_win_bad;
      end
      if (r_state == ST_ISSUE)     r_tmo <= '0;
      else if (r_state == ST_BUSY) r_tmo <= w_tmo_inc;
      r_gap <= (r_state == ST_GAP) ? r_gap + GW'(1) : '0;
      if (r_state == ST_BUSY && eng_done) begin
        if (r_win_data) r_d_rdata <= eng_rdata;
        else            r_f_rdata <= eng_rdata;
      end
    end
  end

  assign eng_sel   = r_sel;
  assign eng_addr  = r_addr;
  assign eng_write = r_write;
  assign eng_size  = r_size;
  assign eng_wdata = r_wdata;
  assign f_rdata   = r_f_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: doc/qspi_bus_arbiter.md
# qspi_bus_arbiter

Schedules the shared QSPI engine between the CPU instruction-fetch port and the CPU data port. The QSPI clock/data pins are common to flash (CS uio[0]) and RAM_A (CS uio[6]), and each access is routed by address bits [24:23]. The block sits between the CPU memory interfaces and the QSPI serializer engine. It grants one transaction at a time, enforces a minimum chip-select idle gap, bounds fetch starvation of data accesses, rejects illegal accesses and recovers from a hung engine.

## Interface
Parameters:
- FETCH_STREAK, 4: maximum consecutive fetch grants while d_req is pending.
- CS_GAP, 2: idle cycles between the end of one transaction and the next eng_start. May be 0.
- TIMEOUT, 1023: BUSY cycles without eng_done before abort. Counter is 10 bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- f_req  in  1  fetch request. Held, with f_addr stable, until f_ack.
- f_addr  in  25  fetch byte address. Fetches are always 4-byte reads.
- f_ack  out  1  one-cycle completion pulse for the fetch port.
- f_err  out  1  qualifies f_ack as an error.
- f_rdata  out  32  fetch read data, valid with f_ack.
- d_req  in  1  data request. Held, with all d_* inputs stable, until d_ack.
- d_addr  in  25  data byte address.
- d_write  in  1  1 = write.
- d_size  in  2  access size: 0 = 1 B, 1 = 2 B, 2 = 4 B, 3 = illegal.
- d_wdata  in  32  write data.
- d_ack  out  1  one-cycle completion pulse for the data port.
- d_err  out  1  qualifies d_ack as an error.
- d_rdata  out  32  data read data, valid with d_ack.
- eng_start  out  1  one-cycle transaction start to the engine.
- eng_sel  out  2  target: winner addr[24:23]. 00 = flash, 10 = RAM_A, 11 = RAM_B.
- eng_addr  out  23  winner addr[22:0].
- eng_write  out  1  write transaction.
- eng_size  out  2  transaction size, same encoding as d_size.
- eng_wdata  out  32  write data.
- eng_abort  out  1  one-cycle abort on timeout. Engine releases CS.
- eng_done  in  1  one-cycle transaction completion from the engine.
- eng_rdata  in  32  engine read data, valid with eng_done.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, BUSY, ACK, ERR, GAP.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner. Fetch wins unless d_req is high and streak == FETCH_STREAK; then data wins.
  - Capture the winner's sel, addr, write, size and wdata into registers. Record the winner ID.
  - If the winner is illegal, go to ERR. Otherwise go to ISSUE.
- Illegal accesses:
  - addr[24:23] == 01.
  - Data write with addr[24:23] == 00 (flash is read-only).
  - d_size == 3.
- ISSUE: eng_start = 1 for exactly this cycle. eng_* outputs are registered and stable from ISSUE through the last BUSY cycle. Next state is BUSY, with the timeout counter cleared.
- BUSY:
  - eng_done == 1: latch eng_rdata into the winner's rdata register, go to ACK.
  - Timeout counter reaches TIMEOUT: pulse eng_abort, go to ERR.
  - eng_done and timeout in the same cycle: eng_done wins.
- ACK: winner ack = 1, err = 0 for one cycle. Then go to GAP, or to IDLE if CS_GAP == 0.
- ERR: winner ack = 1, err = 1 for one cycle. Illegal accesses skip GAP and go to IDLE. Timeouts go to GAP.
- GAP: count CS_GAP cycles, then go to IDLE. No requests are sampled.
- Streak counter, 3 bits, saturating:
  - Increments on each fetch grant made while d_req is high.
  - Clears on any data grant.
  - Clears on any fetch grant made while d_req is low.
- rdata registers hold their value until the next ack to the same port.
- The non-winning port's ack/err are never asserted.

## Timing
- Reset: state IDLE, streak 0, timeout counter 0. All outputs are 0, including rdata and eng_* buses.
- Reset mid-transaction: state returns to IDLE on the next edge and no ack is issued. The engine shares rst_n.
- Read/write latency: request seen in IDLE at cycle N → eng_start at N+1. eng_done at cycle M → ack at M+1. Next IDLE sampling at M+2+CS_GAP.
- eng_done is sampled only in BUSY. A pulse in any other state is ignored.
- Error latency: illegal request at N → ack+err at N+1 → IDLE at N+2.
- A requester deasserts or changes its request in the cycle after ack. Requests are not sampled during ACK, ERR or GAP.
- Timeout: abort at BUSY cycle TIMEOUT, ack+err on the following cycle.

## Structure
- Shared package holds:
  - Target encodings: SEL_FLASH = 2'b00, SEL_RAMA = 2'b10, SEL_RAMB = 2'b11, SEL_BAD = 2'b01.
  - Size encodings.
  - The state enum.
- Sub-module qspi_arb_pick: combinational winner selection plus the streak counter register.
- The FSM, capture registers and timeout/gap counters live in the top module.

## Test plan
- Single fetch: f_req, f_addr = 0x000100; engine done 5 cycles after start with rdata 0xDEADBEEF → eng_sel = 00, eng_addr = 0x000100, f_ack 1 cycle after done, f_rdata = 0xDEADBEEF, eng_start again no sooner than 2 cycles after f_ack (CS_GAP = 2).
- Data write to RAM_A: d_addr = 0x1000040, size 2, wdata 0x12345678 → eng_sel = 10, eng_addr = 0x000040, eng_write = 1, d_ack with d_err = 0.
- Starvation: f_req and d_req held continuously → exactly 4 fetch grants, then 1 data grant, then the fetch sequence restarts.
- Illegal accesses: d_addr = 0x0800000; write to 0x0000010; d_size = 3 → d_ack + d_err 1 cycle after sampling, eng_start never asserted.
- Timeout: engine never answers → eng_abort at BUSY cycle 1023, f_ack + f_err next cycle, then GAP, then IDLE. eng_done coinciding with the timeout cycle → normal ack, no abort.
- Reset mid-BUSY: rst_n low 1 cycle → IDLE, all outputs 0, no ack. A new request afterwards completes normally.
